// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: the NOP word returned
// on faulting fetches, the response FIFO occupancy states and the helper that
// sizes the word index from the memory depth.
package imem_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occState_t;

  function automatic int imemIndexWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO for the instruction fetch memory. An occupancy FSM
// (EMPTY/ONE/FULL) produces registered ready/valid flags, so the upstream
// ready never depends combinationally on the downstream ready.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_popReady,
  output logic             o_pushReady,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_headData
);

  occState_t        r_state;
  logic             r_pushReady;
  logic             r_valid;
  logic             r_rdPtr;
  logic             r_wrPtr;
  logic [WIDTH-1:0] r_entry [2];
  logic             w_push;
  logic             w_pop;

  assign w_push      = i_push && r_pushReady;
  assign w_pop       = r_valid && i_popReady;
  assign o_pushReady = r_pushReady;
  assign o_valid     = r_valid;
  assign o_headData  = r_valid ? r_entry[r_rdPtr] : '0;

  // Occupancy FSM with registered flags; ready stays low until the first edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= EMPTY;
      r_pushReady <= 1'b0;
      r_valid     <= 1'b0;
      r_rdPtr     <= 1'b0;
      r_wrPtr     <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      case (r_state)
        EMPTY: begin
          r_pushReady <= 1'b1;
          if (w_push) begin
            r_state <= ONE;
            r_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_state     <= FULL;
            r_pushReady <= 1'b0;
          end else if (!w_push && w_pop) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state     <= ONE;
            r_pushReady <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_pushReady <= 1'b1;
          r_valid     <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage needs no reset; the head is masked by the valid flag.
  always_ff @(posedge i_clk) begin
    if (w_push) r_entry[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/instruction_fetch_memory.sv
// Instruction fetch memory: word-addressed array with a program-load write
// port and a registered request/response fetch path through a 2-entry FIFO.
// Misaligned or out-of-range fetches return the NOP word with an error flag.
// Optional macro IMEM_PARITY_EN adds an even-parity bit per word and the
// RspParityErr output flagging a read parity mismatch.
module instruction_fetch_memory
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspInstruction,
  output logic                  RspError,
`ifdef IMEM_PARITY_EN
  output logic                  RspParityErr,
`endif
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddress,
  input  logic [DATA_WIDTH-1:0] LoadData
);

  localparam int IDX_W = imemIndexWidth(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int ENTRY_W = DATA_WIDTH + 2;
`else
  localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic                  r_parity [DEPTH];
  logic                  w_parityErr;
`endif
  logic [IDX_W-1:0]      w_reqIndex;
  logic [IDX_W-1:0]      w_loadIndex;
  logic                  w_reqError;
  logic                  w_loadOk;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_fetchData;
  logic [ENTRY_W-1:0]    w_pushEntry;
  logic [ENTRY_W-1:0]    w_headEntry;

  assign w_reqIndex  = ReqAddress[IDX_W+1:2];
  assign w_loadIndex = LoadAddress[IDX_W+1:2];
  assign w_reqError  = (ReqAddress[1:0] != 2'b00) || ((ReqAddress >> (IDX_W + 2)) != '0);
  assign w_loadOk    = LoadEn && (LoadAddress[1:0] == 2'b00) &&
                       ((LoadAddress >> (IDX_W + 2)) == '0);
  assign w_accept    = ReqValid && ReqReady;
  assign w_fetchData = w_reqError ? DATA_WIDTH'(NOP_INSTRUCTION) : r_mem[w_reqIndex];

`ifdef IMEM_PARITY_EN
  assign w_parityErr = !w_reqError && ((^r_mem[w_reqIndex]) != r_parity[w_reqIndex]);
  assign w_pushEntry = {w_parityErr, w_reqError, w_fetchData};
  assign RspParityErr = w_headEntry[DATA_WIDTH+1];
`else
  assign w_pushEntry = {w_reqError, w_fetchData};
`endif
  assign RspInstruction = w_headEntry[DATA_WIDTH-1:0];
  assign RspError       = w_headEntry[DATA_WIDTH];

  // Program-load port; the array is not reset and a same-edge fetch sees the old word.
  always_ff @(posedge Clk) begin
    if (w_loadOk) begin
      r_mem[w_loadIndex] <= LoadData;
`ifdef IMEM_PARITY_EN
      r_parity[w_loadIndex] <= ^LoadData;
`endif
    end
  end

  imem_rsp_fifo #(
    .WIDTH(ENTRY_W)
  ) u_rspFifo (
    .i_clk      (Clk),
    .i_rst_n    (Rst),
    .i_push     (w_accept),
    .i_pushData (w_pushEntry),
    .i_popReady (RspReady),
    .o_pushReady(ReqReady),
    .o_valid    (RspValid),
    .o_headData (w_headEntry)
  );

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed testbench for instruction_fetch_memory (default 32-bit, 128 words).
module tb_instruction_fetch_memory;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] ReqAddress = '0;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] RspInstruction;
  logic        RspError;
`ifdef IMEM_PARITY_EN
  logic        RspParityErr;
`endif
  logic        LoadEn = 1'b0;
  logic [31:0] LoadAddress = '0;
  logic [31:0] LoadData = '0;

  int total = 0;
  int bad = 0;

  instruction_fetch_memory dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqAddress    (ReqAddress),
    .RspValid      (RspValid),
    .RspReady      (RspReady),
    .RspInstruction(RspInstruction),
    .RspError      (RspError),
`ifdef IMEM_PARITY_EN
    .RspParityErr  (RspParityErr),
`endif
    .LoadEn        (LoadEn),
    .LoadAddress   (LoadAddress),
    .LoadData      (LoadData)
  );

  always #5 Clk = ~Clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
    LoadEn = 1'b1; LoadAddress = addr; LoadData = data;
    step();
    LoadEn = 1'b0;
  endtask

  task automatic test_reset();
    #1 Rst = 1'b0;
    #2;
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", ReqReady); end
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", RspValid); end
    total++; if (RspInstruction !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", RspInstruction); end
    total++; if (RspError !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", RspError); end
    step(); step();
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_ready got=%b want=0", ReqReady); end
    Rst = 1'b1;
    step();
    total++; if (ReqReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", ReqReady); end
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_valid got=%b want=0", RspValid); end
  endtask

  task automatic test_basic_fetch();
    loadWord(32'h0, 32'h2008_0005);
    loadWord(32'h4, 32'h2009_0003);
    RspReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h0;
    step();
    total++; if (RspValid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid0 got=%b want=1", RspValid); end
    total++; if (RspInstruction !== 32'h2008_0005) begin bad++; $display("[TB] FAIL basic_instr0 got=%h want=20080005", RspInstruction); end
    total++; if (RspError !== 1'b0) begin bad++; $display("[TB] FAIL basic_err0 got=%b want=0", RspError); end
    ReqAddress = 32'h4;
    step();
    total++; if (RspValid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid1 got=%b want=1", RspValid); end
    total++; if (RspInstruction !== 32'h2009_0003) begin bad++; $display("[TB] FAIL basic_instr1 got=%h want=20090003", RspInstruction); end
    total++; if (ReqReady !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready got=%b want=1", ReqReady); end
    ReqValid = 1'b0;
    step();
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain got=%b want=0", RspValid); end
    RspReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    RspReady = 1'b0; ReqValid = 1'b1; ReqAddress = 32'h0;
    step();
    total++; if (ReqReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_one got=%b want=1", ReqReady); end
    ReqAddress = 32'h4;
    step();
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_full got=%b want=0", ReqReady); end
    ReqAddress = 32'h0;
    step(); step();
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_third_blocked got=%b want=0", ReqReady); end
    total++; if (RspInstruction !== 32'h2008_0005) begin bad++; $display("[TB] FAIL bp_head_stable got=%h want=20080005", RspInstruction); end
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    total++; if (ReqReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after_pop got=%b want=1", ReqReady); end
    total++; if (RspInstruction !== 32'h2009_0003) begin bad++; $display("[TB] FAIL bp_second got=%h want=20090003", RspInstruction); end
    step();
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_third_accepted got=%b want=0", ReqReady); end
    ReqValid = 1'b0; RspReady = 1'b1;
    step();
    total++; if (RspInstruction !== 32'h2008_0005) begin bad++; $display("[TB] FAIL bp_third_data got=%h want=20080005", RspInstruction); end
    total++; if (RspValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_third_valid got=%b want=1", RspValid); end
    step();
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%b want=0", RspValid); end
    RspReady = 1'b0;
  endtask

  task automatic test_errors();
    loadWord(32'h1FC, 32'hCAFE_F00D);
    loadWord(32'h6, 32'hFFFF_FFFF);
    loadWord(32'h204, 32'h0000_0BAD);
    RspReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h2;
    step();
    total++; if (RspInstruction !== 32'h0) begin bad++; $display("[TB] FAIL err_mis_instr got=%h want=0", RspInstruction); end
    total++; if (RspError !== 1'b1) begin bad++; $display("[TB] FAIL err_mis_flag got=%b want=1", RspError); end
    ReqAddress = 32'h200;
    step();
    total++; if (RspInstruction !== 32'h0) begin bad++; $display("[TB] FAIL err_oor_instr got=%h want=0", RspInstruction); end
    total++; if (RspError !== 1'b1) begin bad++; $display("[TB] FAIL err_oor_flag got=%b want=1", RspError); end
    ReqAddress = 32'h1FC;
    step();
    total++; if (RspInstruction !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL err_last_instr got=%h want=cafef00d", RspInstruction); end
    total++; if (RspError !== 1'b0) begin bad++; $display("[TB] FAIL err_last_flag got=%b want=0", RspError); end
    ReqAddress = 32'h4;
    step();
    total++; if (RspInstruction !== 32'h2009_0003) begin bad++; $display("[TB] FAIL err_bad_load_ignored got=%h want=20090003", RspInstruction); end
    ReqValid = 1'b0;
    step();
    RspReady = 1'b0;
  endtask

  task automatic test_same_edge();
    loadWord(32'h8, 32'h1234_5678);
    LoadEn = 1'b1; LoadAddress = 32'h8; LoadData = 32'hDEAD_BEEF;
    RspReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h8;
    step();
    LoadEn = 1'b0;
    total++; if (RspInstruction !== 32'h1234_5678) begin bad++; $display("[TB] FAIL same_edge_old got=%h want=12345678", RspInstruction); end
    step();
    total++; if (RspInstruction !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL same_edge_new got=%h want=deadbeef", RspInstruction); end
    ReqValid = 1'b0;
    step();
    RspReady = 1'b0;
  endtask

  task automatic test_reset_midop();
    RspReady = 1'b0; ReqValid = 1'b1; ReqAddress = 32'h0;
    step();
    ReqAddress = 32'h4;
    step();
    ReqValid = 1'b0;
    total++; if (ReqReady !== 1'b0) begin bad++; $display("[TB] FAIL mid_full got=%b want=0", ReqReady); end
    #1 Rst = 1'b0;
    #1;
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid_cleared got=%b want=0", RspValid); end
    total++; if (RspInstruction !== 32'h0) begin bad++; $display("[TB] FAIL mid_instr_cleared got=%h want=0", RspInstruction); end
    step();
    Rst = 1'b1;
    step();
    total++; if (ReqReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_after got=%b want=1", ReqReady); end
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_discarded got=%b want=0", RspValid); end
    RspReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h0;
    step();
    ReqValid = 1'b0;
    total++; if (RspInstruction !== 32'h2008_0005) begin bad++; $display("[TB] FAIL mid_mem_kept got=%h want=20080005", RspInstruction); end
    step();
    total++; if (RspValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_drain got=%b want=0", RspValid); end
    RspReady = 1'b0;
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    dut.r_mem[1] = dut.r_mem[1] ^ 32'h1;
    RspReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h4;
    step();
    total++; if (RspParityErr !== 1'b1) begin bad++; $display("[TB] FAIL parity_flip got=%b want=1", RspParityErr); end
    total++; if (RspInstruction !== 32'h2009_0002) begin bad++; $display("[TB] FAIL parity_data got=%h want=20090002", RspInstruction); end
    ReqAddress = 32'h0;
    step();
    total++; if (RspParityErr !== 1'b0) begin bad++; $display("[TB] FAIL parity_clean got=%b want=0", RspParityErr); end
    ReqValid = 1'b0;
    step();
    RspReady = 1'b0;
  endtask
`endif

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_errors();
    test_same_edge();
    test_reset_midop();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
